// File: rtl/wallace_mult_pkg.sv
// Shared types and constants for the iterative 8x8 nibble multiplier.
package wallace_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;
    localparam int OP_W  = 8;
    localparam int STEPS = 4;

    // Nibble-product weight: 4 * (step[0] + step[1]).
    function automatic logic [3:0] sh(input logic [1:0] step);
        return {step[0] & step[1], step[0] ^ step[1], 2'b00};
    endfunction

endpackage

// File: rtl/wallace_unsigned_multiplier_4.sv
// Combinational 4x4 unsigned multiplier: four partial-product rows
// reduced by two 3:2 carry-save layers and one final adder.
module wallace_unsigned_multiplier_4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    logic [7:0] r0, r1, r2, r3;
    logic [7:0] s1, c1, s2, c2;

    assign r0 = {4'b0000, a_i & {4{b_i[0]}}};
    assign r1 = {3'b000, a_i & {4{b_i[1]}}, 1'b0};
    assign r2 = {2'b00, a_i & {4{b_i[2]}}, 2'b00};
    assign r3 = {1'b0, a_i & {4{b_i[3]}}, 3'b000};

    assign s1 = r0 ^ r1 ^ r2;
    assign c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;

    assign s2 = s1 ^ c1 ^ r3;
    assign c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;

    assign p_o = s2 + c2;

endmodule

// File: rtl/wallace_mult_seq_8.sv
// Iterative 8x8 unsigned multiplier: one 4x4 array time-shared over
// four nibble steps, with valid/ready handshakes on both sides.
module wallace_mult_seq_8
    import wallace_mult_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] A,
    input  logic [OP_W-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     product,
    output logic            busy
);

    state_t          state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic [OP_W-1:0] a_q, a_d;
    logic [OP_W-1:0] b_q, b_d;
    logic [15:0]     acc_q, acc_d;
    logic [15:0]     prod_q, prod_d;

    logic [NIB_W-1:0] a_nib, b_nib;
    logic [7:0]       pp;
    logic [15:0]      acc_sum;
    logic             accept;
    logic             zero_op;

    assign a_nib = step_q[0] ? a_q[7:4] : a_q[3:0];
    assign b_nib = step_q[1] ? b_q[7:4] : b_q[3:0];

    wallace_unsigned_multiplier_4 u_mul4 (
        .a_i (a_nib),
        .b_i (b_nib),
        .p_o (pp)
    );

    assign acc_sum = acc_q + ({8'h00, pp} << sh(step_q));
    assign accept  = in_valid && in_ready;
    assign zero_op = ZERO_SKIP && ((A == '0) || (B == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= 16'h0000;
            prod_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d    = A;
                    b_d    = B;
                    acc_d  = 16'h0000;
                    step_d = 2'd0;
                    if (zero_op) begin
                        state_d = DONE;
                        prod_d  = 16'h0000;
                    end else begin
                        state_d = MUL;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'(STEPS - 1)) begin
                    state_d = DONE;
                    prod_d  = acc_sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q == MUL);
        product   = prod_q;
    end

endmodule

// File: tb/tb_wallace_mult_seq_8.sv
// Bench for wallace_mult_seq_8: directed handshake cases plus random
// traffic, both against a cycle-level behavioural model and scoreboard.
module tb_wallace_mult_seq_8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  A, B;
    logic [1:0]  ir_w, ov_w, bz_w;
    logic [15:0] p_w [2];

    int tests  = 0;
    int errors = 0;

    // dut index 1 has zero-skip enabled, index 0 has it disabled
    wallace_mult_seq_8 #(.ZERO_SKIP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w[1]),
        .A(A), .B(B), .out_valid(ov_w[1]), .out_ready(out_ready),
        .product(p_w[1]), .busy(bz_w[1])
    );

    wallace_mult_seq_8 #(.ZERO_SKIP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w[0]),
        .A(A), .B(B), .out_valid(ov_w[0]), .out_ready(out_ready),
        .product(p_w[0]), .busy(bz_w[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: cycles left until result, pending result, held result.
    int          m_cnt [2];
    bit          m_val [2];
    logic [15:0] m_prod [2];
    logic [15:0] m_pend [2];
    logic [15:0] sb [2][$];

    function automatic bit m_ir(input int i);
        return (m_cnt[i] == 0 && !m_val[i]) || (m_val[i] && out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]  = 0;
                m_val[i]  = 1'b0;
                m_prod[i] = 16'h0000;
                m_pend[i] = 16'h0000;
                sb[i].delete();
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit acc;
                acc = in_valid && m_ir(i);
                if (m_val[i] && out_ready) m_val[i] = 1'b0;
                if (m_cnt[i] > 0) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_val[i]  = 1'b1;
                        m_prod[i] = m_pend[i];
                    end
                end
                if (acc) begin
                    m_pend[i] = 16'(A) * 16'(B);
                    sb[i].push_back(m_pend[i]);
                    if (i == 1 && (A == 8'h00 || B == 8'h00)) begin
                        m_val[i]  = 1'b1;
                        m_prod[i] = 16'h0000;
                    end else begin
                        m_cnt[i] = 4;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int i,
                       input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, i, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk("in_ready", i, 32'(ir_w[i]), 32'(m_ir(i)));
                chk("out_valid", i, 32'(ov_w[i]), 32'(m_val[i]));
                chk("busy", i, 32'(bz_w[i]), 32'(m_cnt[i] > 0));
                chk("product", i, 32'(p_w[i]), 32'(m_prod[i]));
                if (ov_w[i] && out_ready) begin
                    if (sb[i].size() == 0) begin
                        chk("sb_unexpected", i, 32'(p_w[i]), 32'hFFFF_FFFF);
                    end else begin
                        chk("sb_order", i, 32'(p_w[i]), 32'(sb[i].pop_front()));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (7) tick();
    endtask

    // Present one operand pair to dut i; report edges after accept until
    // out_valid, busy cycles seen, and the product shown.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input int i,
                      output int lat, output int bsy, output logic [15:0] p);
        int n;
        n = 0;
        A = a;
        B = b;
        in_valid = 1'b1;
        while (!ir_w[i] && n < 50) begin
            tick();
            n++;
        end
        chk("accept_wait", i, 32'(n < 50), 32'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        #1;
        lat = 0;
        bsy = 0;
        while (!ov_w[i] && lat < 20) begin
            bsy += int'(bz_w[i]);
            @(posedge clk);
            #3;
            lat++;
        end
        p = p_w[i];
    endtask

    initial begin
        int          lat, bsy;
        logic [15:0] p;
        int          n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        repeat (3) tick();
        chk("rst_in_ready", 1, 32'(ir_w[1]), 32'd1);
        chk("rst_out_valid", 1, 32'(ov_w[1]), 32'd0);
        chk("rst_product", 1, 32'(p_w[1]), 32'h0000);
        chk("rst_busy", 1, 32'(bz_w[1]), 32'd0);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        op(8'hFF, 8'hFF, 1, lat, bsy, p);
        chk("ff_lat", 1, 32'(lat), 32'd4);
        chk("ff_busy", 1, 32'(bsy), 32'd4);
        chk("ff_prod", 1, 32'(p), 32'hFE01);
        tick();
        chk("ff_in_ready", 1, 32'(ir_w[1]), 32'd1);

        drain();
        op(8'h00, 8'h5A, 1, lat, bsy, p);
        chk("zs_lat", 1, 32'(lat), 32'd0);
        chk("zs_busy", 1, 32'(bsy), 32'd0);
        chk("zs_prod", 1, 32'(p), 32'h0000);
        drain();
        op(8'h00, 8'h5A, 0, lat, bsy, p);
        chk("nzs_lat", 0, 32'(lat), 32'd4);
        chk("nzs_busy", 0, 32'(bsy), 32'd4);
        chk("nzs_prod", 0, 32'(p), 32'h0000);

        drain();
        out_ready = 1'b0;
        op(8'h12, 8'h34, 1, lat, bsy, p);
        chk("bp_lat", 1, 32'(lat), 32'd4);
        chk("bp_prod", 1, 32'(p), 32'h03A8);
        repeat (10) begin
            tick();
            chk("bp_hold_valid", 1, 32'(ov_w[1]), 32'd1);
            chk("bp_hold_prod", 1, 32'(p_w[1]), 32'h03A8);
            chk("bp_in_ready", 1, 32'(ir_w[1]), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", 1, 32'(ov_w[1]), 32'd0);

        drain();
        A = 8'h12;
        B = 8'h34;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        A = 8'hAB;
        B = 8'hCD;
        #1;
        n = 0;
        while (!ov_w[1] && n < 20) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("b2b_first", 1, 32'(p_w[1]), 32'h03A8);
        chk("b2b_ready", 1, 32'(ir_w[1]), 32'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        #1;
        lat = 0;
        while (!ov_w[1] && lat < 20) begin
            @(posedge clk);
            #3;
            lat++;
        end
        chk("b2b_lat", 1, 32'(lat), 32'd4);
        chk("b2b_second", 1, 32'(p_w[1]), 32'h88EF);

        drain();
        A = 8'hFF;
        B = 8'h02;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 1, 32'(ov_w[1]), 32'd0);
        chk("abort_prod", 1, 32'(p_w[1]), 32'h0000);
        chk("abort_ready", 1, 32'(ir_w[1]), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        op(8'h03, 8'h05, 1, lat, bsy, p);
        chk("after_abort_prod", 1, 32'(p), 32'h000F);
        chk("after_abort_lat", 1, 32'(lat), 32'd4);

        drain();
        repeat (15000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            A = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            B = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            tick();
        end
        drain();
        chk("sb_empty", 1, 32'(sb[1].size()), 32'd0);
        chk("sb_empty", 0, 32'(sb[0].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
